i2c_reg_ctrl: RTL and testbench
===============================

# i2c_reg_ctrl

Register-file controller behind the NORA I2C slave port. It turns the slave's raw byte stream into indexed register accesses:
- the first written byte after addressing sets a register pointer;
- following writes store to registers, and reads return register contents, with pointer auto-increment.

It also arbitrates the register file between the I2C side and the CPU-side bus port, so the 65xx host and an external I2C master share one register bank.

## Interface
Parameters:
- AW, 4: register address width; the bank holds 2^AW 8-bit registers.
- RST_VAL, 8'h00: reset value of every register.

Ports:
- clk6x  in  1  system clock, 48 MHz.
- resetn  in  1  reset, synchronous, active-low.
- devsel_i  in  1  slave addressed, transfer ongoing.
- rw_bit_i  in  1  1 = master reads; valid while devsel_i=1.
- rxbyte_i  in  8  received data byte.
- rxbyte_v_i  in  1  1T strobe, rxbyte_i valid.
- txbyte_o  out  8  next byte for the slave to transmit.
- txbyte_deq_i  in  1  1T strobe, slave consumed txbyte_o.
- tx_nacked_i  in  1  1T strobe, master NACKed the last byte.
- cpu_req_i  in  1  CPU access request; level, held until ack.
- cpu_we_i  in  1  1 = write.
- cpu_addr_i  in  AW  CPU register index.
- cpu_wdata_i  in  8  CPU write data.
- cpu_ack_o  out  1  1T, access done.
- cpu_rdata_o  out  8  read data, valid with cpu_ack_o.
- i2c_wr_o  out  1  1T, I2C master wrote a register.
- i2c_wr_addr_o  out  AW  index written; valid with i2c_wr_o.
- ptr_o  out  AW  current register pointer, for debug/status.

## Operation
FSM states:
- IDLE: no transfer.
  - On devsel_i rise with rw_bit_i=0, go to WAIT_PTR.
  - On devsel_i rise with rw_bit_i=1, go to RD_DATA.
- WAIT_PTR: on rxbyte_v_i, ptr <= rxbyte_i[AW-1:0] (upper bits ignored); go to WR_DATA.
- WR_DATA: on rxbyte_v_i:
  - reg[ptr] <= rxbyte_i;
  - i2c_wr_o=1 and i2c_wr_addr_o=ptr, next cycle;
  - ptr <= ptr+1.
- RD_DATA: on txbyte_deq_i, ptr <= ptr+1.
  - tx_nacked_i causes no ptr change; the FSM stays in RD_DATA until devsel_i falls.
- Any state: devsel_i=0 returns to IDLE next cycle. ptr is retained across transactions, so a write-pointer / repeated-START / read sequence reads from the set pointer.
- A devsel_i drop and re-rise (repeated START) passes through IDLE for 1T. That is sufficient because the slave deasserts devsel_i for ≥1T at any START.

txbyte_o:
- Registered: txbyte_o <= reg[ptr] every cycle, with write-forwarding. If the cycle's write (I2C or CPU) targets ptr, txbyte_o takes the new data.

Pointer arithmetic:
- Modulo 2^AW; 2^AW-1 wraps to 0.

Arbitration:
- I2C writes cannot stall, so the I2C side has absolute priority.
- A CPU request is granted in any cycle with no I2C register write. Otherwise it waits 1 cycle.
- Ack is given in the cycle after grant.

Reset values:
- Registers = RST_VAL; ptr=0; state IDLE.
- All outputs 0, except txbyte_o=RST_VAL.

## Timing
- CPU access latency: cpu_req_i rise → cpu_ack_o 1 cycle later without conflict, 2 cycles with an I2C write in the grant cycle.
- A new request is accepted only in the cycle after ack; cpu_req_i held high re-requests.
- CPU read returns the value after any same-cycle I2C write (read-after-write ordering).
- Same-cycle same-address I2C and CPU writes: the I2C write applies first; the CPU write applies one cycle later and is the final value.
- Register write visible in txbyte_o 1 cycle after the write cycle. ptr change visible in txbyte_o 1 cycle after the update. Both are well inside the slave's ≥10T output delay.
- i2c_wr_o lags rxbyte_v_i by 1 cycle.
- Reset mid-transfer: immediate return to reset values. The in-flight CPU request is dropped, with no ack, and must be re-issued.
- rxbyte_v_i while in IDLE or RD_DATA is ignored. txbyte_deq_i outside RD_DATA is ignored.

## Configuration
- I2C_REG_CTRL_AUTOINC_EN:
  - Defined: ptr increments after each data write and each txbyte_deq_i, as above.
  - Undefined: ptr changes only in WAIT_PTR, so repeated reads or writes hit the same register (FIFO-style port use).

## Structure
- Shared package i2c_reg_pkg holds:
  - state enum: IDLE, WAIT_PTR, WR_DATA, RD_DATA;
  - default AW;
  - RST_VAL.
- One sub-module, i2c_regfile: 2^AW×8 array, one write port, two async read ports (ptr, cpu_addr). All arbitration stays in i2c_reg_ctrl.

## Test plan
- I2C write 0x03, 0xAA, 0xBB → reg3=0xAA, reg4=0xBB, ptr=5; two i2c_wr_o pulses with addr 3 then 4.
- Write pointer 0x0F, then repeated-START read of 3 bytes with reg15=0x11, reg0=0x22, reg1=0x33 → txbyte_o sequence 0x11, 0x22, 0x33 (wrap); ptr=2.
- CPU write reg7=0x5A, then CPU read reg7 → ack 1 cycle after each request; rdata=0x5A.
- CPU write reg2=0x77 in the same cycle as an I2C data write 0x99 to reg2 → ack delayed to 2 cycles; final reg2=0x77.
- Master NACK after the first read byte, then devsel_i drop → ptr incremented by 1 only; state IDLE.
- resetn low mid-write with cpu_req_i pending → all registers RST_VAL, ptr=0, no cpu_ack_o; without I2C_REG_CTRL_AUTOINC_EN, writes 0x05, 0x01, 0x02 leave reg5=0x02.

Source files
------------

// File: rtl/i2c_reg_pkg.sv
// Shared types and defaults for the I2C register-file controller.
// Build option: define I2C_REG_CTRL_AUTOINC_EN for pointer auto-increment.
package i2c_reg_pkg;

  localparam int unsigned DefaultAw     = 4;
  localparam logic [7:0]  DefaultRstVal = 8'h00;

  typedef enum logic [1:0] {
    StIdle,
    StWaitPtr,
    StWrData,
    StRdData
  } state_e;

endpackage

// File: rtl/i2c_regfile.sv
// 2^AW x 8 register bank: one synchronous write port, two async read ports.
module i2c_regfile import i2c_reg_pkg::*; #(
  parameter int unsigned AW      = DefaultAw,
  parameter logic [7:0]  RST_VAL = DefaultRstVal
) (
  input  logic          clk6x,
  input  logic          resetn,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_a_i,
  output logic [7:0]    rdata_a_o,
  input  logic [AW-1:0] raddr_b_i,
  output logic [7:0]    rdata_b_o
);

  localparam int unsigned Depth = 2 ** AW;

  logic [7:0] mem_q [Depth];

  // Register storage with synchronous reset to RST_VAL.
  always_ff @(posedge clk6x) begin
    if (!resetn) begin
      mem_q <= '{default: RST_VAL};
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/i2c_reg_ctrl.sv
// I2C slave byte stream to indexed register accesses, sharing the bank with a CPU port.
// Build option: I2C_REG_CTRL_AUTOINC_EN enables pointer auto-increment on data/dequeue.
module i2c_reg_ctrl import i2c_reg_pkg::*; #(
  parameter int unsigned AW      = DefaultAw,
  parameter logic [7:0]  RST_VAL = DefaultRstVal
) (
  input  logic          clk6x,
  input  logic          resetn,
  input  logic          devsel_i,
  input  logic          rw_bit_i,
  input  logic [7:0]    rxbyte_i,
  input  logic          rxbyte_v_i,
  output logic [7:0]    txbyte_o,
  input  logic          txbyte_deq_i,
  input  logic          tx_nacked_i,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [7:0]    cpu_wdata_i,
  output logic          cpu_ack_o,
  output logic [7:0]    cpu_rdata_o,
  output logic          i2c_wr_o,
  output logic [AW-1:0] i2c_wr_addr_o,
  output logic [AW-1:0] ptr_o
);

`ifdef I2C_REG_CTRL_AUTOINC_EN
  localparam bit AutoInc = 1'b1;
`else
  localparam bit AutoInc = 1'b0;
`endif

  state_e        state_q;
  logic          devsel_q;
  logic [AW-1:0] ptr_q;
  logic          i2c_wr_q;
  logic [AW-1:0] i2c_wr_addr_q;
  logic          cpu_ack_q;
  logic [7:0]    cpu_rdata_q;
  logic [7:0]    txbyte_q;

  logic          i2c_we;
  logic          cpu_grant;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [7:0]    rf_wdata;
  logic [7:0]    rd_ptr_data;
  logic [7:0]    rd_cpu_data;

  // A NACK never moves the pointer; the FSM just waits in RdData for devsel to drop.
  logic unused_nack;
  assign unused_nack = tx_nacked_i;

  // I2C data writes cannot stall, so the CPU is only granted in cycles without one.
  // The ack cycle itself blocks a new grant, so a held request re-issues one cycle later.
  assign i2c_we    = devsel_i && rxbyte_v_i && (state_q == StWrData);
  assign cpu_grant = cpu_req_i && !i2c_we && !cpu_ack_q;

  // Single write-port mux; i2c_we and cpu_grant are mutually exclusive.
  always_comb begin
    rf_we    = i2c_we || (cpu_grant && cpu_we_i);
    rf_waddr = i2c_we ? ptr_q : cpu_addr_i;
    rf_wdata = i2c_we ? rxbyte_i : cpu_wdata_i;
  end

  i2c_regfile #(
    .AW      (AW),
    .RST_VAL (RST_VAL)
  ) u_regfile (
    .clk6x     (clk6x),
    .resetn    (resetn),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata),
    .raddr_a_i (ptr_q),
    .rdata_a_o (rd_ptr_data),
    .raddr_b_i (cpu_addr_i),
    .rdata_b_o (rd_cpu_data)
  );

  // Transfer FSM, register pointer and I2C write notification.
  always_ff @(posedge clk6x) begin
    if (!resetn) begin
      state_q       <= StIdle;
      devsel_q      <= 1'b0;
      ptr_q         <= '0;
      i2c_wr_q      <= 1'b0;
      i2c_wr_addr_q <= '0;
    end else begin
      devsel_q <= devsel_i;
      i2c_wr_q <= i2c_we;
      if (i2c_we) begin
        i2c_wr_addr_q <= ptr_q;
      end
      if (!devsel_i) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (!devsel_q) begin
              state_q <= rw_bit_i ? StRdData : StWaitPtr;
            end
          end
          StWaitPtr: begin
            if (rxbyte_v_i) begin
              ptr_q   <= rxbyte_i[AW-1:0];
              state_q <= StWrData;
            end
          end
          StWrData: begin
            if (rxbyte_v_i && AutoInc) begin
              ptr_q <= ptr_q + 1'b1;
            end
          end
          StRdData: begin
            if (txbyte_deq_i && AutoInc) begin
              ptr_q <= ptr_q + 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // CPU ack/read data and the transmit byte, forwarded from a same-cycle write to ptr.
  always_ff @(posedge clk6x) begin
    if (!resetn) begin
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      txbyte_q    <= RST_VAL;
    end else begin
      cpu_ack_q <= cpu_grant;
      if (cpu_grant && !cpu_we_i) begin
        cpu_rdata_q <= rd_cpu_data;
      end
      txbyte_q <= (rf_we && (rf_waddr == ptr_q)) ? rf_wdata : rd_ptr_data;
    end
  end

  assign txbyte_o      = txbyte_q;
  assign cpu_ack_o     = cpu_ack_q;
  assign cpu_rdata_o   = cpu_rdata_q;
  assign i2c_wr_o      = i2c_wr_q;
  assign i2c_wr_addr_o = i2c_wr_addr_q;
  assign ptr_o         = ptr_q;

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Directed bench for i2c_reg_ctrl: CPU vector table plus hand-written I2C sequences.
// Expectations follow I2C_REG_CTRL_AUTOINC_EN when it is defined for the build.
module tb_i2c_reg_ctrl;

`ifdef I2C_REG_CTRL_AUTOINC_EN
  localparam bit AutoInc = 1'b1;
`else
  localparam bit AutoInc = 1'b0;
`endif

  logic       clk6x;
  logic       resetn;
  logic       devsel_i;
  logic       rw_bit_i;
  logic [7:0] rxbyte_i;
  logic       rxbyte_v_i;
  logic [7:0] txbyte_o;
  logic       txbyte_deq_i;
  logic       tx_nacked_i;
  logic       cpu_req_i;
  logic       cpu_we_i;
  logic [3:0] cpu_addr_i;
  logic [7:0] cpu_wdata_i;
  logic       cpu_ack_o;
  logic [7:0] cpu_rdata_o;
  logic       i2c_wr_o;
  logic [3:0] i2c_wr_addr_o;
  logic [3:0] ptr_o;

  int checks = 0;
  int errors = 0;

  i2c_reg_ctrl #(
    .AW      (4),
    .RST_VAL (8'h00)
  ) dut (
    .clk6x         (clk6x),
    .resetn        (resetn),
    .devsel_i      (devsel_i),
    .rw_bit_i      (rw_bit_i),
    .rxbyte_i      (rxbyte_i),
    .rxbyte_v_i    (rxbyte_v_i),
    .txbyte_o      (txbyte_o),
    .txbyte_deq_i  (txbyte_deq_i),
    .tx_nacked_i   (tx_nacked_i),
    .cpu_req_i     (cpu_req_i),
    .cpu_we_i      (cpu_we_i),
    .cpu_addr_i    (cpu_addr_i),
    .cpu_wdata_i   (cpu_wdata_i),
    .cpu_ack_o     (cpu_ack_o),
    .cpu_rdata_o   (cpu_rdata_o),
    .i2c_wr_o      (i2c_wr_o),
    .i2c_wr_addr_o (i2c_wr_addr_o),
    .ptr_o         (ptr_o)
  );

  initial clk6x = 1'b0;
  always #5 clk6x = ~clk6x;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } cpu_vec_t;

  cpu_vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk6x);
    #1;
  endtask

  task automatic i2c_start(input logic rw);
    devsel_i = 1'b1;
    rw_bit_i = rw;
    step();
    step();
  endtask

  task automatic i2c_stop();
    devsel_i = 1'b0;
    step();
  endtask

  task automatic i2c_send(input logic [7:0] b, input logic exp_wr, input logic [3:0] exp_addr);
    rxbyte_i   = b;
    rxbyte_v_i = 1'b1;
    step();
    rxbyte_v_i = 1'b0;
    chk("i2c_wr pulse", 32'(i2c_wr_o), 32'(exp_wr));
    if (exp_wr) chk("i2c_wr_addr", 32'(i2c_wr_addr_o), 32'(exp_addr));
    step();
    chk("i2c_wr 1T", 32'(i2c_wr_o), 32'd0);
    step();
  endtask

  task automatic cpu_access(input logic we, input logic [3:0] addr, input logic [7:0] wd,
                            output logic [7:0] rd, output int lat);
    cpu_req_i   = 1'b1;
    cpu_we_i    = we;
    cpu_addr_i  = addr;
    cpu_wdata_i = wd;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!cpu_ack_o && lat < 8);
    rd = cpu_rdata_o;
    cpu_req_i = 1'b0;
    step();
    chk("cpu_ack 1T", 32'(cpu_ack_o), 32'd0);
  endtask

  task automatic cpu_read_chk(input string name, input logic [3:0] addr, input logic [7:0] exp);
    logic [7:0] rd;
    int lat;
    cpu_access(1'b0, addr, 8'h00, rd, lat);
    chk(name, 32'(rd), 32'(exp));
  endtask

  initial begin
    logic [7:0] rd;
    int         lat;
    logic [7:0] exp_tx[3];

    resetn       = 1'b0;
    devsel_i     = 1'b0;
    rw_bit_i     = 1'b0;
    rxbyte_i     = 8'h00;
    rxbyte_v_i   = 1'b0;
    txbyte_deq_i = 1'b0;
    tx_nacked_i  = 1'b0;
    cpu_req_i    = 1'b0;
    cpu_we_i     = 1'b0;
    cpu_addr_i   = 4'h0;
    cpu_wdata_i  = 8'h00;

    vecs[0]  = '{1'b0, 4'd3,  8'h00, AutoInc ? 8'hAA : 8'hBB};
    vecs[1]  = '{1'b0, 4'd4,  8'h00, AutoInc ? 8'hBB : 8'h00};
    vecs[2]  = '{1'b1, 4'd7,  8'h5A, 8'h00};
    vecs[3]  = '{1'b0, 4'd7,  8'h00, 8'h5A};
    vecs[4]  = '{1'b1, 4'd15, 8'h11, 8'h00};
    vecs[5]  = '{1'b1, 4'd0,  8'h22, 8'h00};
    vecs[6]  = '{1'b1, 4'd1,  8'h33, 8'h00};
    vecs[7]  = '{1'b0, 4'd15, 8'h00, 8'h11};
    vecs[8]  = '{1'b0, 4'd0,  8'h00, 8'h22};
    vecs[9]  = '{1'b0, 4'd1,  8'h00, 8'h33};
    vecs[10] = '{1'b0, 4'd9,  8'h00, 8'h00};

    // Reset state.
    step(); step(); step();
    chk("rst txbyte", 32'(txbyte_o), 32'h00);
    chk("rst ptr", 32'(ptr_o), 32'h0);
    chk("rst cpu_ack", 32'(cpu_ack_o), 32'h0);
    chk("rst i2c_wr", 32'(i2c_wr_o), 32'h0);
    chk("rst cpu_rdata", 32'(cpu_rdata_o), 32'h0);
    resetn = 1'b1;
    step();

    // I2C write: pointer 3, then 0xAA, 0xBB.
    i2c_start(1'b0);
    i2c_send(8'h03, 1'b0, 4'd0);
    i2c_send(8'hAA, 1'b1, 4'd3);
    i2c_send(8'hBB, 1'b1, AutoInc ? 4'd4 : 4'd3);
    i2c_stop();
    chk("wr ptr", 32'(ptr_o), AutoInc ? 32'd5 : 32'd3);

    // CPU vector table.
    for (int i = 0; i < 11; i++) begin
      cpu_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'd1);
      if (!vecs[i].we) chk($sformatf("vec%0d rdata", i), 32'(rd), 32'(vecs[i].exp_rd));
    end

    // Pointer 0x0F then repeated-START read of three bytes, wrapping through 0.
    exp_tx[0] = 8'h11;
    exp_tx[1] = AutoInc ? 8'h22 : 8'h11;
    exp_tx[2] = AutoInc ? 8'h33 : 8'h11;
    i2c_start(1'b0);
    i2c_send(8'hFF, 1'b0, 4'd0);
    devsel_i = 1'b0;
    step();
    i2c_start(1'b1);
    chk("rd ptr set", 32'(ptr_o), 32'd15);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rd byte%0d", k), 32'(txbyte_o), 32'(exp_tx[k]));
      txbyte_deq_i = 1'b1;
      step();
      txbyte_deq_i = 1'b0;
      step();
      step();
    end
    i2c_stop();
    chk("rd ptr wrap", 32'(ptr_o), AutoInc ? 32'd2 : 32'd15);

    // NACK after first byte: one increment only, then IDLE ignores rx/deq strobes.
    i2c_start(1'b1);
    txbyte_deq_i = 1'b1;
    step();
    txbyte_deq_i = 1'b0;
    step();
    tx_nacked_i = 1'b1;
    step();
    tx_nacked_i = 1'b0;
    step();
    step();
    i2c_stop();
    step();
    chk("nack ptr", 32'(ptr_o), AutoInc ? 32'd3 : 32'd15);
    i2c_send(8'h0A, 1'b0, 4'd0);
    chk("idle rx ignored", 32'(ptr_o), AutoInc ? 32'd3 : 32'd15);
    txbyte_deq_i = 1'b1;
    step();
    txbyte_deq_i = 1'b0;
    step();
    chk("idle deq ignored", 32'(ptr_o), AutoInc ? 32'd3 : 32'd15);

    // Same-cycle I2C and CPU write to reg2: CPU waits a cycle and wins.
    i2c_start(1'b0);
    i2c_send(8'h02, 1'b0, 4'd0);
    cpu_req_i   = 1'b1;
    cpu_we_i    = 1'b1;
    cpu_addr_i  = 4'd2;
    cpu_wdata_i = 8'h77;
    rxbyte_i    = 8'h99;
    rxbyte_v_i  = 1'b1;
    step();
    rxbyte_v_i = 1'b0;
    chk("conflict ack stalled", 32'(cpu_ack_o), 32'd0);
    chk("conflict i2c_wr", 32'(i2c_wr_o), 32'd1);
    chk("conflict i2c_wr_addr", 32'(i2c_wr_addr_o), 32'd2);
    chk("conflict tx fwd i2c", 32'(txbyte_o), 32'h99);
    step();
    chk("conflict ack", 32'(cpu_ack_o), 32'd1);
    chk("conflict tx", 32'(txbyte_o), AutoInc ? 32'hAA : 32'h77);
    cpu_req_i = 1'b0;
    step();
    i2c_stop();
    cpu_read_chk("conflict reg2", 4'd2, 8'h77);

    // Reset mid-write with a CPU request pending.
    i2c_start(1'b0);
    i2c_send(8'h05, 1'b0, 4'd0);
    i2c_send(8'h01, 1'b1, 4'd5);
    cpu_req_i   = 1'b1;
    cpu_we_i    = 1'b1;
    cpu_addr_i  = 4'd4;
    cpu_wdata_i = 8'hEE;
    resetn      = 1'b0;
    devsel_i    = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("rst%0d no ack", c), 32'(cpu_ack_o), 32'd0);
    end
    chk("midrst ptr", 32'(ptr_o), 32'd0);
    chk("midrst txbyte", 32'(txbyte_o), 32'h00);
    chk("midrst i2c_wr", 32'(i2c_wr_o), 32'd0);
    cpu_req_i = 1'b0;
    resetn    = 1'b1;
    step();
    cpu_read_chk("midrst reg5", 4'd5, 8'h00);
    cpu_read_chk("midrst reg15", 4'd15, 8'h00);
    cpu_read_chk("midrst reg4", 4'd4, 8'h00);

    // Writes 0x05, 0x01, 0x02: FIFO-style without auto-increment.
    i2c_start(1'b0);
    i2c_send(8'h05, 1'b0, 4'd0);
    i2c_send(8'h01, 1'b1, 4'd5);
    i2c_send(8'h02, 1'b1, AutoInc ? 4'd6 : 4'd5);
    i2c_stop();
    chk("fifo ptr", 32'(ptr_o), AutoInc ? 32'd7 : 32'd5);
    cpu_read_chk("fifo reg5", 4'd5, AutoInc ? 8'h01 : 8'h02);
    cpu_read_chk("fifo reg6", 4'd6, AutoInc ? 8'h02 : 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
